// File: rtl/mux_a_pkg.sv
// Shared constants for the mux_a block: default widths, pipeline depth bounds
// and the in2 extension-mode encodings.
package mux_a_pkg;

    localparam int W_IN1_DEF = 32;
    localparam int W_IN2_DEF = 16;

    localparam int PIPE_MIN = 1;
    localparam int PIPE_MAX = 4;

    localparam int EXT_ZERO = 0;
    localparam int EXT_SIGN = 1;

endpackage : mux_a_pkg

// File: rtl/mux_a_pipe_reg.sv
// One output pipeline stage: a W-bit register that clears asynchronously.
module mux_a_pipe_reg
    import mux_a_pkg::*;
#(
    parameter int W = W_IN1_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture every edge; reset clears without waiting for the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule : mux_a_pipe_reg

// File: rtl/mux_a.sv
// 2:1 select between a full-width source and a zero/sign-extended narrow
// source, followed by PIPE_STAGES register stages. outA comes only from flops.
module mux_a
    import mux_a_pkg::*;
#(
    parameter int W_IN1       = W_IN1_DEF,
    parameter int W_IN2       = W_IN2_DEF,
    parameter int EXT_SIGNED  = EXT_ZERO,
    parameter int PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W_IN1-1:0] in1,
    input  logic [W_IN2-1:0] in2,
    input  logic             sel,
    output logic [W_IN1-1:0] outA
);

    // Reject illegal configurations at elaboration time.
    if (W_IN2 < 1 || W_IN2 > W_IN1) begin : g_bad_width
        $error("mux_a: W_IN2 (%0d) must be in 1..W_IN1 (%0d)", W_IN2, W_IN1);
    end
    if (PIPE_STAGES < PIPE_MIN || PIPE_STAGES > PIPE_MAX) begin : g_bad_pipe
        $error("mux_a: PIPE_STAGES (%0d) must be in %0d..%0d",
               PIPE_STAGES, PIPE_MIN, PIPE_MAX);
    end
    if (EXT_SIGNED != EXT_ZERO && EXT_SIGNED != EXT_SIGN) begin : g_bad_ext
        $error("mux_a: EXT_SIGNED (%0d) must be 0 or 1", EXT_SIGNED);
    end

    logic [W_IN1-1:0] in2_ext;
    logic [W_IN1-1:0] sel_val;
    logic [W_IN1-1:0] stage [0:PIPE_STAGES];

    // Equal widths leave nothing to fill, so EXT_SIGNED has no effect there.
    if (W_IN1 == W_IN2) begin : g_no_ext
        assign in2_ext = in2;
    end else begin : g_ext
        localparam int FILL_W = W_IN1 - W_IN2;
        logic fill;
        assign fill    = (EXT_SIGNED == EXT_SIGN) ? in2[W_IN2-1] : 1'b0;
        assign in2_ext = {{FILL_W{fill}}, in2};
    end

    // Plain 2:1 select feeding stage 0; an unknown sel gets no special treatment.
    always_comb begin
        sel_val = in2_ext;
        if (sel) begin
            sel_val = in1;
        end
    end

    assign stage[0] = sel_val;

    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_pipe
        mux_a_pipe_reg #(
            .W (W_IN1)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (stage[i]),
            .q     (stage[i+1])
        );
    end

    assign outA = stage[PIPE_STAGES];

endmodule : mux_a

// File: tb/tb_mux_a.sv
// Self-checking bench for mux_a: three configurations driven from shared
// inputs and checked every cycle against a cycle-indexed reference history.
module tb_mux_a;

    localparam int W1 = 32;
    localparam int W2 = 16;

    logic          clk;
    logic          rst_n;
    logic [W1-1:0] in1;
    logic [W2-1:0] in2;
    logic          sel;
    logic [W1-1:0] out_z1;
    logic [W1-1:0] out_s1;
    logic [W1-1:0] out_z3;

    int checks   = 0;
    int failures = 0;

    // Reference history: value selected at post-reset edge k, per extension mode.
    logic [W1-1:0] hist_z [0:2047];
    logic [W1-1:0] hist_s [0:2047];
    int            k = 0;

    mux_a #(.W_IN1(W1), .W_IN2(W2), .EXT_SIGNED(0), .PIPE_STAGES(1)) u_z1 (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .sel(sel), .outA(out_z1));
    mux_a #(.W_IN1(W1), .W_IN2(W2), .EXT_SIGNED(1), .PIPE_STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .sel(sel), .outA(out_s1));
    mux_a #(.W_IN1(W1), .W_IN2(W2), .EXT_SIGNED(0), .PIPE_STAGES(3)) u_z3 (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .sel(sel), .outA(out_z3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Selection rule stated arithmetically: sign extension adds 2^32 - 2^16
    // to a negative 16-bit value.
    function automatic logic [W1-1:0] model(input logic [W1-1:0] a,
                                            input logic [W2-1:0] b,
                                            input logic s,
                                            input bit sgn);
        int unsigned v;
        if (s) return a;
        v = b;
        if (sgn && b >= 16'h8000) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    task automatic check(input string name, input logic [W1-1:0] act,
                         input logic [W1-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W1-1:0] expected(input bit sgn, input int p);
        if (!rst_n || k < p) return '0;
        return sgn ? hist_s[k-p+1] : hist_z[k-p+1];
    endfunction

    // Record what each edge samples, then compare all outputs shortly after.
    always @(posedge clk) begin
        if (!rst_n) begin
            k = 0;
        end else begin
            k = k + 1;
            hist_z[k] = model(in1, in2, sel, 1'b0);
            hist_s[k] = model(in1, in2, sel, 1'b1);
        end
        #1;
        check("cmp_z1", out_z1, expected(1'b0, 1));
        check("cmp_s1", out_s1, expected(1'b1, 1));
        check("cmp_z3", out_z3, expected(1'b0, 3));
    end

    initial begin
        logic [W2-1:0] corner [0:3];
        corner[0] = 16'h0000;
        corner[1] = 16'h7FFF;
        corner[2] = 16'h8000;
        corner[3] = 16'hFFFF;

        // Pin the reference model with hand-computed values.
        check("pin_sel1",   model(32'hA5A5_A5A5, 16'h1234, 1'b1, 1'b1), 32'hA5A5_A5A5);
        check("pin_zext",   model(32'hB6B6_B6B6, 16'hFFFF, 1'b0, 1'b0), 32'h0000_FFFF);
        check("pin_sext_n", model(32'hB6B6_B6B6, 16'h8000, 1'b0, 1'b1), 32'hFFFF_8000);
        check("pin_sext_p", model(32'hB6B6_B6B6, 16'h7FFF, 1'b0, 1'b1), 32'h0000_7FFF);

        rst_n = 1'b0;
        in1   = '0;
        in2   = '0;
        sel   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_z1", out_z1, 32'h0);
        check("reset_z3", out_z3, 32'h0);

        rst_n = 1'b1;
        sel = 1'b1; in1 = 32'hA5A5_A5A5; in2 = 16'h1234;
        @(posedge clk); #2;
        check("sel1_a5", out_z1, 32'hA5A5_A5A5);

        @(negedge clk);
        sel = 1'b0; in1 = 32'hB6B6_B6B6; in2 = 16'h5678;
        @(posedge clk); #2;
        check("zext_5678", out_z1, 32'h0000_5678);
        check("sext_5678", out_s1, 32'h0000_5678);

        @(negedge clk);
        sel = 1'b1; in1 = 32'hC7C7_C7C7; in2 = 16'hABCD;
        @(posedge clk); #2;
        check("sel1_c7", out_s1, 32'hC7C7_C7C7);

        @(negedge clk);
        sel = 1'b0;
        @(posedge clk); #2;
        check("zext_abcd", out_z1, 32'h0000_ABCD);
        check("sext_abcd", out_s1, 32'hFFFF_ABCD);

        // Asynchronous reset between edges while outA holds C7C7C7C7.
        @(negedge clk);
        sel = 1'b1; in1 = 32'hC7C7_C7C7;
        @(posedge clk); #2;
        check("pre_rst_c7", out_z1, 32'hC7C7_C7C7);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_z1", out_z1, 32'h0);
        check("async_rst_z3", out_z3, 32'h0);
        @(posedge clk); #2;
        check("rst_hold", out_z1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        in1 = 32'h1111_2222;
        #1;
        check("after_release", out_z3, 32'h0);
        @(posedge clk); #2;
        check("first_after_rel", out_z1, 32'h1111_2222);

        // Alternating sel with distinct values through the three-stage pipe.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in1 = 32'h1000_0000 + i;
            in2 = 16'h2000 + 16'(i);
            sel = i[0];
            @(posedge clk); #2;
            if (i == 2) check("pipe3_first", out_z3, 32'h0000_2000);
            if (i == 3) check("pipe3_second", out_z3, 32'h1000_0001);
        end

        // Random sweep with in2 biased toward the sign-boundary corners.
        repeat (1000) begin
            @(negedge clk);
            in1 = $urandom;
            sel = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 1) == 1) in2 = corner[$urandom_range(0, 3)];
            else                           in2 = 16'($urandom);
        end

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux_a

// File: doc/mux_a.md
MUX_A -- requirements
Module: mux_a

Interface
REQ-001 Parameter W_IN1, default 32: width of in1 and outA.
REQ-002 Parameter W_IN2, default 16: width of in2; the block SHALL require W_IN2 <= W_IN1 (elaboration error otherwise).
REQ-003 Parameter EXT_SIGNED, default 0: extension mode for in2; 0 = zero-extend, 1 = sign-extend.
REQ-004 Parameter PIPE_STAGES, default 1: number of output register stages; the allowed range SHALL be 1..4.
REQ-005 Port clk, input, 1: single rising-edge clock.
REQ-006 Port rst_n, input, 1: reset, asynchronous assert and active-low.
REQ-007 Port in1, input, W_IN1: full-width source, selected when sel=1.
REQ-008 Port in2, input, W_IN2: narrow source, extended to W_IN1 and selected when sel=0.
REQ-009 Port sel, input, 1: source select; 1 selects in1, 0 selects extended in2.
REQ-010 Port outA, output, W_IN1: registered selected value.

Function
REQ-011 Extended in2 SHALL be {(W_IN1-W_IN2) fill bits, in2}; the fill SHALL be 0 when EXT_SIGNED=0 and in2[W_IN2-1] when EXT_SIGNED=1.
REQ-012 The selected value SHALL be in1 when sel=1 and extended in2 when sel=0.
REQ-013 sel=X/Z SHALL NOT be given special handling; selection SHALL be a plain 2:1 mux.
REQ-014 The selected value SHALL be captured on every rising clk edge; there is no enable and no handshake.
REQ-015 Latency SHALL be exactly PIPE_STAGES clock edges from input sampling to outA; with the default setting, outA after edge N equals the selection of inputs sampled at edge N.
REQ-016 outA SHALL be driven only by flops, with no combinational path from any input to outA.
REQ-017 Throughput SHALL be one new result per cycle, and back-to-back sel changes SHALL be honoured every cycle.
REQ-018 When W_IN1 == W_IN2, no extension SHALL occur and EXT_SIGNED SHALL be ignored.

Reset
REQ-019 When rst_n=0, every pipeline stage and outA SHALL clear to 0 immediately, without waiting for a clk edge.
REQ-020 On rst_n deassertion, the first valid outA SHALL appear PIPE_STAGES edges after the first sampling edge.
REQ-021 Reset asserted mid-stream SHALL discard all in-flight values; nothing stale SHALL emerge after release.

Structure
REQ-022 Package mux_a_pkg SHALL hold the width defaults (32/16), the PIPE_STAGES bounds and the extension-mode constants.
REQ-023 One sub-module, mux_a_pipe_reg, SHALL be used: a W-bit register with asynchronous active-low clear, instantiated PIPE_STAGES times in a generate loop.
REQ-024 Extension and selection logic SHALL stay in mux_a as combinational logic ahead of stage 0.

Verification
REQ-025 sel=1, in1=A5A5A5A5, in2=1234 -> outA=A5A5A5A5 after one edge.
REQ-026 sel=0, in1=B6B6B6B6, in2=5678 -> outA=00005678 after one edge.
REQ-027 sel=1, in1=C7C7C7C7, in2=ABCD -> outA=C7C7C7C7; then sel=0 with EXT_SIGNED=1 and in2=ABCD -> outA=FFFFABCD, while EXT_SIGNED=0 -> outA=0000ABCD.
REQ-028 rst_n pulled low between clock edges while outA=C7C7C7C7 -> outA=00000000 at once, and it stays 0 until the first edge after release.
REQ-029 PIPE_STAGES=3 with sel toggling every cycle and distinct in1/in2 values -> outA reproduces the input sequence delayed by exactly 3 edges, with no gaps.
REQ-030 Random sweep of 1000 cycles checked against a reference model of REQ-011/012/015, covering in2 at 0000, 7FFF, 8000 and FFFF in both EXT_SIGNED modes.
